// File: rtl/cook_sequencer_if.sv
// Handshake bundle between the cook sequencer and its panel/timer neighbours.
// slave = sequencer side; master = buttons, door switch, keypad encoder and timer side.
interface cook_sequencer_if;
  logic       start_btn;
  logic       stop_btn;
  logic       clear_btn;
  logic       door_closed;
  logic       key_valid;
  logic       timer_zero;
  logic       mag_on;
  logic       timer_load;
  logic       timer_clear;
  logic       sec_tick;
  logic       done;
  logic [2:0] state;
`ifdef ADD30_EN
  logic       timer_add30;
`endif

  modport slave (
`ifdef ADD30_EN
    output timer_add30,
`endif
    input  start_btn, stop_btn, clear_btn, door_closed, key_valid, timer_zero,
    output mag_on, timer_load, timer_clear, sec_tick, done, state
  );

  modport master (
`ifdef ADD30_EN
    input  timer_add30,
`endif
    output start_btn, stop_btn, clear_btn, door_closed, key_valid, timer_zero,
    input  mag_on, timer_load, timer_clear, sec_tick, done, state
  );
endinterface

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: IDLE/READY/COOK/PAUSE/DONE with an internal 1 s divider. Every output is
// registered and moves one edge after its cause; no backpressure. ADD30_EN adds the +30 s start pulse.
module cook_sequencer #(
  parameter int DIV_COUNT    = 50000000,
  parameter int DONE_SECONDS = 3
) (
  input logic             clk,
  input logic             rst_n,
  cook_sequencer_if.slave sq
);
  localparam int DW = $clog2(DIV_COUNT);
  localparam int SW = $clog2(DONE_SECONDS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_COUNT - 1);
  localparam logic [SW-1:0] SEC_MAX = SW'(DONE_SECONDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] secs_q, secs_d;
  logic          start_q, stop_q, clear_q;
  logic          mag_on_q, done_q, timer_load_q, timer_clear_q, sec_tick_q;
  logic          load_d, clr_d, tick_d;
  logic          start_e, stop_e, clear_e, wrap;
  logic [DW-1:0] div_inc;
`ifdef ADD30_EN
  logic          add30_q, add30_d;
`endif

  assign start_e = sq.start_btn & ~start_q;
  assign stop_e  = sq.stop_btn  & ~stop_q;
  assign clear_e = sq.clear_btn & ~clear_q;
  assign wrap    = (div_q == DIV_MAX);
  assign div_inc = wrap ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    secs_d  = secs_q;
    load_d  = 1'b0;
    clr_d   = 1'b0;
    tick_d  = 1'b0;
`ifdef ADD30_EN
    add30_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (clear_e) clr_d = 1'b1;
        else if (sq.key_valid) begin
          load_d  = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        if (clear_e || stop_e) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (start_e && sq.door_closed && !sq.timer_zero) begin
          state_d = COOK;
          div_d   = '0;
`ifdef ADD30_EN
        end else if (start_e && sq.door_closed) begin
          state_d = COOK;
          div_d   = '0;
          add30_d = 1'b1;
`endif
        end else if (sq.key_valid) load_d = 1'b1;
      end
      COOK: begin
        // Divider is left untouched on the way to PAUSE so a resume finishes the partial second.
        if (clear_e) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (stop_e || !sq.door_closed) state_d = PAUSE;
        else if (sq.timer_zero) begin
          state_d = DONE;
          div_d   = '0;
          secs_d  = '0;
        end else begin
          div_d  = div_inc;
          tick_d = wrap;
`ifdef ADD30_EN
          add30_d = start_e;
`endif
        end
      end
      PAUSE: begin
        if (clear_e || stop_e) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (start_e && sq.door_closed) state_d = COOK;
      end
      DONE: begin
        if (start_e || stop_e || clear_e || !sq.door_closed) state_d = IDLE;
        else if (sq.key_valid) begin
          load_d  = 1'b1;
          state_d = READY;
        end else begin
          div_d  = div_inc;
          tick_d = wrap;
          if (wrap) begin
            if (secs_q == SEC_MAX) state_d = IDLE;
            else secs_d = secs_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_q         <= '0;
      secs_q        <= '0;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      clear_q       <= 1'b0;
      mag_on_q      <= 1'b0;
      done_q        <= 1'b0;
      timer_load_q  <= 1'b0;
      timer_clear_q <= 1'b0;
      sec_tick_q    <= 1'b0;
`ifdef ADD30_EN
      add30_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      secs_q        <= secs_d;
      start_q       <= sq.start_btn;
      stop_q        <= sq.stop_btn;
      clear_q       <= sq.clear_btn;
      mag_on_q      <= (state_d == COOK);
      done_q        <= (state_d == DONE);
      timer_load_q  <= load_d;
      timer_clear_q <= clr_d;
      sec_tick_q    <= tick_d;
`ifdef ADD30_EN
      add30_q       <= add30_d;
`endif
    end
  end

  assign sq.state       = state_q;
  assign sq.mag_on      = mag_on_q;
  assign sq.done        = done_q;
  assign sq.timer_load  = timer_load_q;
  assign sq.timer_clear = timer_clear_q;
  assign sq.sec_tick    = sec_tick_q;
`ifdef ADD30_EN
  assign sq.timer_add30 = add30_q;
`endif
endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with a cycle-level behavioural model checked every cycle.
module tb_cook_sequencer;
  localparam int DIV   = 4;
  localparam int DSECS = 2;
`ifdef ADD30_EN
  localparam bit ADD30 = 1'b1;
`else
  localparam bit ADD30 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  cook_sequencer_if sq();

  cook_sequencer #(.DIV_COUNT(DIV), .DONE_SECONDS(DSECS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (sq.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_run counts cooking cycles since the cook (or done phase) began; a second elapses
  // whenever it reaches a multiple of DIV, and the done phase ends after DSECS such seconds.
  int m_state, m_run, e_state;
  bit m_valid = 1'b0;
  bit p_start, p_stop, p_clear;
  bit e_mag, e_load, e_clr, e_tick, e_done, e_add30;

  always @(posedge clk) begin : model
    bit se, pe, ce, counting;
    int nxt;
    if (!rst_n) begin
      m_state = 0; m_run = 0; e_state = 0;
      p_start = 0; p_stop = 0; p_clear = 0;
      e_mag = 0; e_load = 0; e_clr = 0; e_tick = 0; e_done = 0; e_add30 = 0;
    end else begin
      se = sq.start_btn && !p_start;
      pe = sq.stop_btn  && !p_stop;
      ce = sq.clear_btn && !p_clear;
      p_start = sq.start_btn; p_stop = sq.stop_btn; p_clear = sq.clear_btn;
      nxt = m_state; counting = 0;
      e_load = 0; e_clr = 0; e_tick = 0; e_add30 = 0;
      case (m_state)
        0: if (ce) e_clr = 1;
           else if (sq.key_valid) begin e_load = 1; nxt = 1; end
        1: if (ce || pe) begin e_clr = 1; nxt = 0; end
           else if (se && sq.door_closed && (!sq.timer_zero || ADD30)) begin
             nxt = 2; m_run = 0; e_add30 = sq.timer_zero;
           end else if (sq.key_valid) e_load = 1;
        2: if (ce) begin e_clr = 1; nxt = 0; end
           else if (pe || !sq.door_closed) nxt = 3;
           else if (sq.timer_zero) begin nxt = 4; m_run = 0; end
           else begin counting = 1; e_add30 = ADD30 && se; end
        3: if (ce || pe) begin e_clr = 1; nxt = 0; end
           else if (se && sq.door_closed) nxt = 2;
        4: if (se || pe || ce || !sq.door_closed) nxt = 0;
           else if (sq.key_valid) begin e_load = 1; nxt = 1; end
           else counting = 1;
        default: nxt = 0;
      endcase
      if (counting) begin
        m_run++;
        e_tick = (m_run % DIV == 0);
        if (m_state == 4 && m_run >= DIV * DSECS) nxt = 0;
      end
      m_state = nxt;
      e_state = nxt;
      e_mag   = (nxt == 2);
      e_done  = (nxt == 4);
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc.state", int'(sq.state), e_state);
      chk("cyc.mag_on", int'(sq.mag_on), int'(e_mag));
      chk("cyc.timer_load", int'(sq.timer_load), int'(e_load));
      chk("cyc.timer_clear", int'(sq.timer_clear), int'(e_clr));
      chk("cyc.sec_tick", int'(sq.sec_tick), int'(e_tick));
      chk("cyc.done", int'(sq.done), int'(e_done));
`ifdef ADD30_EN
      chk("cyc.timer_add30", int'(sq.timer_add30), int'(e_add30));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_pulse();
    sq.key_valid = 1'b1;
    step(1);
    sq.key_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sq.start_btn = 0; sq.stop_btn = 0; sq.clear_btn = 0;
    sq.door_closed = 1; sq.key_valid = 0; sq.timer_zero = 0;

    // Reset and first digit
    step(2);
    chk("t1.rst_state", int'(sq.state), 0);
    chk("t1.rst_mag", int'(sq.mag_on), 0);
    chk("t1.rst_done", int'(sq.done), 0);
    chk("t1.rst_load", int'(sq.timer_load), 0);
    rst_n = 1'b1;
    step(1);
    key_pulse();
    chk("t1.load", int'(sq.timer_load), 1);
    chk("t1.ready", int'(sq.state), 1);
    step(1);
    chk("t1.load_end", int'(sq.timer_load), 0);

    // Cook, tick cadence, done hold time
    sq.start_btn = 1;
    step(1);
    chk("t2.cook", int'(sq.state), 2);
    chk("t2.mag", int'(sq.mag_on), 1);
    sq.start_btn = 0;
    step(3);
    chk("t2.no_tick", int'(sq.sec_tick), 0);
    step(1);
    chk("t2.tick1", int'(sq.sec_tick), 1);
    step(4);
    chk("t2.tick2", int'(sq.sec_tick), 1);
    sq.timer_zero = 1;
    step(1);
    chk("t2.done_state", int'(sq.state), 4);
    chk("t2.done_mag", int'(sq.mag_on), 0);
    chk("t2.done", int'(sq.done), 1);
    sq.timer_zero = 0;
    step(7);
    chk("t2.done_last", int'(sq.done), 1);
    step(1);
    chk("t2.done_off", int'(sq.done), 0);
    chk("t2.idle", int'(sq.state), 0);

    // Door opens at divider 2, pause keeps the partial second
    key_pulse();
    sq.start_btn = 1;
    step(1);
    sq.start_btn = 0;
    step(2);
    sq.door_closed = 0;
    step(1);
    chk("t3.pause", int'(sq.state), 3);
    chk("t3.pause_mag", int'(sq.mag_on), 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t3.pause_tick", int'(sq.sec_tick), 0);
    end
    sq.door_closed = 1;
    step(1);
    chk("t3.door_shut", int'(sq.state), 3);
    sq.start_btn = 1;
    step(1);
    chk("t3.resume", int'(sq.state), 2);
    sq.start_btn = 0;
    step(1);
    chk("t3.resume_t1", int'(sq.sec_tick), 0);
    step(1);
    chk("t3.resume_t2", int'(sq.sec_tick), 1);

    // Clear+stop+start together in COOK
    sq.clear_btn = 1; sq.stop_btn = 1; sq.start_btn = 1;
    step(1);
    chk("t4.clear", int'(sq.timer_clear), 1);
    chk("t4.idle", int'(sq.state), 0);
    chk("t4.mag", int'(sq.mag_on), 0);
    sq.clear_btn = 0; sq.stop_btn = 0; sq.start_btn = 0;
    step(1);
    chk("t4.clear_end", int'(sq.timer_clear), 0);

    // Held start with door open does not re-trigger
    key_pulse();
    sq.door_closed = 0;
    sq.start_btn = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t5.ready_held", int'(sq.state), 1);
    end
    sq.door_closed = 1;
    step(3);
    chk("t5.no_retrigger", int'(sq.state), 1);
    sq.start_btn = 0;
    step(1);

    // Start with timer at zero; start edge in COOK
    sq.timer_zero = 1; sq.start_btn = 1;
    step(1);
    chk("t6.zero_start", int'(sq.state), ADD30 ? 2 : 1);
`ifdef ADD30_EN
    chk("t6.add30_ready", int'(sq.timer_add30), 1);
`endif
    sq.timer_zero = 0; sq.start_btn = 0;
    step(1);
    if (!ADD30) begin
      sq.start_btn = 1;
      step(1);
      sq.start_btn = 0;
      step(1);
    end
    sq.start_btn = 1;
    step(1);
    chk("t6.cook_start", int'(sq.state), 2);
`ifdef ADD30_EN
    chk("t6.add30_cook", int'(sq.timer_add30), 1);
`endif
    sq.start_btn = 0;
    step(1);
`ifdef ADD30_EN
    chk("t6.add30_end", int'(sq.timer_add30), 0);
`endif

    // Stop beats timer_zero; resume then finishes
    sq.stop_btn = 1; sq.timer_zero = 1;
    step(1);
    chk("t7.stop_wins", int'(sq.state), 3);
    sq.stop_btn = 0; sq.start_btn = 1;
    step(1);
    chk("t7.resume", int'(sq.state), 2);
    sq.start_btn = 0;
    step(1);
    chk("t7.done", int'(sq.state), 4);
    sq.door_closed = 0;
    step(1);
    chk("t7.door_exit", int'(sq.state), 0);
    sq.door_closed = 1; sq.timer_zero = 0;
    step(1);

    // Keypad digit during DONE
    key_pulse();
    sq.start_btn = 1;
    step(1);
    sq.start_btn = 0; sq.timer_zero = 1;
    step(1);
    sq.timer_zero = 0;
    step(1);
    key_pulse();
    chk("t8.key_ready", int'(sq.state), 1);
    chk("t8.key_load", int'(sq.timer_load), 1);

    // Reset mid-cook
    sq.start_btn = 1;
    step(1);
    sq.start_btn = 0;
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("t9.rst_mag", int'(sq.mag_on), 0);
    chk("t9.rst_state", int'(sq.state), 0);
    rst_n = 1'b1;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
- Top-level microwave cook controller.
- Sequences the magnetron and the countdown timer from the start/stop/clear buttons, the door switch and keypad-encoder digit strobes.
- Generates the 1 Hz second tick internally.
- Its mag_on output drives the pulse-source select of the timer clock mux: 1 selects the continuous divider pulse, 0 selects the one-shot counter pulse.

Parameters:
DIV_COUNT, 50000000, clk cycles per sec_tick period (>=2)
DONE_SECONDS, 3, seconds done stays asserted after cook end (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start_btn  in  1  start button, active-high level, rising edge detected internally
stop_btn  in  1  stop/pause button, active-high level, edge detected
clear_btn  in  1  clear button, active-high level, edge detected
door_closed  in  1  1 = door shut
key_valid  in  1  one-cycle strobe from BCD keypad encoder, digit ready
timer_zero  in  1  countdown timer reads 00:00
mag_on  out  1  magnetron enable; also the mux select
timer_load  out  1  one-cycle pulse: timer shifts in keypad digit
timer_clear  out  1  one-cycle pulse: timer cleared to 00:00
sec_tick  out  1  one-cycle pulse per elapsed second (COOK and DONE only)
done  out  1  cook-complete indicator
state  out  3  current state code, for display/debug

Behaviour:
- All outputs are registered. All reset to 0; state resets to IDLE; edge registers and divider reset to 0. rst_n is sampled on the clk edge and overrides everything, including mid-COOK (mag_on low the next edge).
- Edge detect: edge = btn & ~btn_q, with btn_q registered each cycle. The FSM acts on the same clk edge that first samples the button high, so outputs change exactly 1 edge after the input rises. A held button produces one edge only.
- Same-cycle priority: clear > stop > door open > start > key_valid.
- States and codes: IDLE=0, READY=1, COOK=2, PAUSE=3, DONE=4; codes 5-7 go to IDLE.
- IDLE:
  - key_valid -> timer_load pulse, go READY.
  - start/stop ignored.
  - clear -> timer_clear pulse.
- READY:
  - key_valid -> timer_load pulse, stay.
  - start & door_closed & !timer_zero -> COOK, divider := 0.
  - start with door open or timer_zero -> ignored.
  - clear or stop -> timer_clear, IDLE.
- COOK:
  - mag_on=1.
  - Divider counts 0..DIV_COUNT-1; sec_tick pulses on the wrap cycle (first tick DIV_COUNT cycles after entry).
  - timer_zero -> DONE, mag_on=0, divider := 0.
  - stop or door open -> PAUSE, divider holds its value.
  - clear -> timer_clear, IDLE.
  - key_valid ignored.
- PAUSE:
  - mag_on=0, no sec_tick, divider frozen.
  - start & door_closed -> COOK, divider resumes from its held value.
  - stop or clear -> timer_clear, IDLE.
  - key_valid ignored.
- DONE:
  - done=1; divider runs, sec_tick pulses.
  - After DONE_SECONDS ticks -> IDLE, done=0.
  - Any button edge or door open -> IDLE early.
  - key_valid -> timer_load, READY.
- timer_zero and stop in the same COOK cycle: stop wins -> PAUSE. Resuming with timer_zero still 1 leads to DONE 1 cycle after COOK re-entry.
- Done-seconds counter width is clog2(DONE_SECONDS+1). The divider is clog2(DIV_COUNT) wide and never exceeds DIV_COUNT-1.

Optional Feature:
ADD30_EN:
- Defined: adds output port timer_add30 (out, 1). A start edge in COOK pulses timer_add30 for 1 cycle; the timer adds 30 s. In READY, a start edge with timer_zero=1 and door_closed pulses timer_add30 and enters COOK.
- Undefined: no port; start is ignored in COOK, and timer_zero blocks start in READY.

Test Plan:
1. Sim params DIV_COUNT=4, DONE_SECONDS=2. Hold rst_n=0 for 2 edges -> all outputs 0, state=0. Release, then key_valid pulse -> timer_load=1 for 1 cycle, state=1.
2. READY, door_closed=1, timer_zero=0, start rise -> mag_on=1 next edge, state=2. sec_tick pulses every 4 cycles. Drive timer_zero=1 -> state=4, mag_on=0, done=1 for 8 cycles, then state=0, done=0.
3. COOK at divider=2: door_closed 1->0 -> state=3, mag_on=0, no sec_tick. Close door: no change. start -> COOK, and the next sec_tick arrives 2 cycles later.
4. Same cycle in COOK: clear=1, stop=1, start=1 -> timer_clear pulse, state=0, mag_on=0.
5. READY with door open, start held high for 10 cycles, then door closed -> stays READY (no re-trigger without a new edge).
6. ADD30_EN defined, COOK: start edge -> timer_add30 pulse of 1 cycle, state stays 2. READY with timer_zero=1: start -> timer_add30 pulse, state=2.
